// File: rtl/ddr5_cmd_seq.sv
// ---------------------------------------------------------------------------
// ddr5_cmd_seq
//
// Closed-page command sequencer sitting in front of the DDR5 CA packet
// generator. Each accepted request is turned into ACT, a tRCD wait, then
// RDA/WRA, then a recovery wait before the next request can be taken.
//
// Output command codes: IDLE=4'd0, ACT=4'd8, WRA=4'd5, RDA=4'd12.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. req_ready is combinational (IDLE and not in
// reset); req_valid may rise or fall freely and has no effect until that
// transfer edge. The req_* payload is only sampled on the transfer edge.
//
// Ports
//   clk            in   1    clock, all logic on posedge
//   rst            in   1    synchronous active-high reset
//   req_valid      in   1    request present
//   req_ready      out  1    sequencer can accept a request
//   req_rd         in   1    1 = read (RDA), 0 = write (WRA)
//   req_bg         in   3    bank group
//   req_ba         in   1    bank
//   req_row        in   16   row address
//   req_col        in   10   column address
//   current_state  out  4    registered command code to packet generator
//   bg/ba/row/col  out  3/1/16/10 registered address fields
//   pkt_cs         out  1    high on the first cycle of ACT, RDA and WRA
//   busy           out  1    high whenever the FSM is not in IDLE
//   dbg_state      out  3    raw FSM state for observation
// ---------------------------------------------------------------------------
module ddr5_cmd_seq #(
    parameter int T_RCD = 8,
    parameter int T_REC = 4,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rd,
    input  logic [2:0]  req_bg,
    input  logic        req_ba,
    input  logic [15:0] req_row,
    input  logic [9:0]  req_col,
    output logic [3:0]  current_state,
    output logic [2:0]  bg,
    output logic        ba,
    output logic [15:0] row,
    output logic [9:0]  col,
    output logic        pkt_cs,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    // Parameter legality is checked at elaboration.
    if (T_RCD < 2) begin : g_rcd_chk
        $error("ddr5_cmd_seq: T_RCD must be >= 2");
    end
    if (T_REC < 0) begin : g_rec_chk
        $error("ddr5_cmd_seq: T_REC must be >= 0");
    end
    if ((T_RCD >= (2 ** CNT_W)) || (T_REC >= (2 ** CNT_W))) begin : g_cnt_chk
        $error("ddr5_cmd_seq: CNT_W too narrow for T_RCD/T_REC");
    end

    localparam logic [3:0] CODE_IDLE = 4'd0;
    localparam logic [3:0] CODE_ACT  = 4'd8;
    localparam logic [3:0] CODE_WRA  = 4'd5;
    localparam logic [3:0] CODE_RDA  = 4'd12;

    // Timer loads (cycles-1) on state entry. ACT and COL last 2 cycles,
    // the tRCD gap lasts T_RCD-2 cycles, recovery lasts T_REC cycles.
    // The guarded expressions avoid negative loads for the skipped states.
    localparam logic [CNT_W-1:0] LOAD_TWO = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOAD_RCD = CNT_W'((T_RCD > 2) ? (T_RCD - 3) : 0);
    localparam logic [CNT_W-1:0] LOAD_REC = CNT_W'((T_REC > 0) ? (T_REC - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACT  = 3'd1,
        S_RCD  = 3'd2,
        S_COL  = 3'd3,
        S_REC  = 3'd4
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] timer, timer_nx;
    logic             rd_q;
    logic             accept;
    logic [3:0]       code_nx;
    logic             cs_nx;

    assign req_ready = (state == S_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // Next-state, timer and next-output logic.
    always_comb begin
        state_nx = state;
        // Count down, saturating at zero.
        timer_nx = (timer != '0) ? (timer - CNT_W'(1)) : '0;
        code_nx  = CODE_IDLE;
        cs_nx    = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = S_ACT;
                    timer_nx = LOAD_TWO;
                end
            end
            S_ACT: begin
                if (timer == '0) begin
                    if (T_RCD == 2) begin
                        state_nx = S_COL;
                        timer_nx = LOAD_TWO;
                    end else begin
                        state_nx = S_RCD;
                        timer_nx = LOAD_RCD;
                    end
                end
            end
            S_RCD: begin
                if (timer == '0) begin
                    state_nx = S_COL;
                    timer_nx = LOAD_TWO;
                end
            end
            S_COL: begin
                if (timer == '0) begin
                    if (T_REC == 0) begin
                        state_nx = S_IDLE;
                        timer_nx = '0;
                    end else begin
                        state_nx = S_REC;
                        timer_nx = LOAD_REC;
                    end
                end
            end
            S_REC: begin
                if (timer == '0) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                timer_nx = '0;
            end
        endcase

        // Outputs are registered, so they are derived from the next state.
        case (state_nx)
            S_ACT:   code_nx = CODE_ACT;
            S_COL:   code_nx = rd_q ? CODE_RDA : CODE_WRA;
            default: code_nx = CODE_IDLE;
        endcase

        // Chip select only on the entry cycle of a command state.
        cs_nx = (state_nx != state) && ((state_nx == S_ACT) || (state_nx == S_COL));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            timer         <= '0;
            current_state <= CODE_IDLE;
            pkt_cs        <= 1'b0;
            rd_q          <= 1'b0;
            bg            <= '0;
            ba            <= 1'b0;
            row           <= '0;
            col           <= '0;
        end else begin
            state         <= state_nx;
            timer         <= timer_nx;
            current_state <= code_nx;
            pkt_cs        <= cs_nx;
            // Address fields hold until the next accepted request.
            if (accept) begin
                rd_q <= req_rd;
                bg   <= req_bg;
                ba   <= req_ba;
                row  <= req_row;
                col  <= req_col;
            end
        end
    end

endmodule

// File: tb/tb_ddr5_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_ddr5_cmd_seq
//
// Two sequencer instances share clock and reset: u_a with T_RCD=8/T_REC=4,
// u_b with T_RCD=2/T_REC=0. Each accepted request pushes its expected ACT
// and column-command records (cycle, code, fields) into a queue; a monitor
// pops and compares whenever pkt_cs is seen. Directed traces additionally
// check the per-cycle command codes, ready and busy against hand tables.
// ---------------------------------------------------------------------------
module tb_ddr5_cmd_seq;

    localparam int RCD_A = 8;
    localparam int REC_A = 4;
    localparam int RCD_B = 2;
    localparam int REC_B = 0;

    // -------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // -------------------------------------------------------------- DUT signals
    logic        valid_a = 1'b0, rd_a = 1'b0, ba_in_a = 1'b0;
    logic [2:0]  bg_in_a = '0;
    logic [15:0] row_in_a = '0;
    logic [9:0]  col_in_a = '0;
    logic        ready_a, cs_a, busy_a, ba_a;
    logic [3:0]  cur_a;
    logic [2:0]  bg_a, dbg_a;
    logic [15:0] row_a;
    logic [9:0]  col_a;

    logic        valid_b = 1'b0, rd_b = 1'b0, ba_in_b = 1'b0;
    logic [2:0]  bg_in_b = '0;
    logic [15:0] row_in_b = '0;
    logic [9:0]  col_in_b = '0;
    logic        ready_b, cs_b, busy_b, ba_b;
    logic [3:0]  cur_b;
    logic [2:0]  bg_b, dbg_b;
    logic [15:0] row_b;
    logic [9:0]  col_b;

    ddr5_cmd_seq #(.T_RCD(RCD_A), .T_REC(REC_A), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(ready_a),
        .req_rd(rd_a), .req_bg(bg_in_a), .req_ba(ba_in_a), .req_row(row_in_a),
        .req_col(col_in_a), .current_state(cur_a), .bg(bg_a), .ba(ba_a),
        .row(row_a), .col(col_a), .pkt_cs(cs_a), .busy(busy_a), .dbg_state(dbg_a)
    );

    ddr5_cmd_seq #(.T_RCD(RCD_B), .T_REC(REC_B), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .req_valid(valid_b), .req_ready(ready_b),
        .req_rd(rd_b), .req_bg(bg_in_b), .req_ba(ba_in_b), .req_row(row_in_b),
        .req_col(col_in_b), .current_state(cur_b), .bg(bg_b), .ba(ba_b),
        .row(row_b), .col(col_b), .pkt_cs(cs_b), .busy(busy_b), .dbg_state(dbg_b)
    );

    // -------------------------------------------------------------- scoreboard
    // Record: [49:34] cycle, [33:30] code, [29:27] bg, [26] ba, [25:10] row, [9:0] col
    logic [49:0] exp_a[$];
    logic [49:0] exp_b[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [49:0] rec(input int c, input logic [3:0] code,
                                        input logic [2:0] b_g, input logic b_a,
                                        input logic [15:0] r, input logic [9:0] c_l);
        logic [15:0] c16;
        c16 = c[15:0];
        return {c16, code, b_g, b_a, r, c_l};
    endfunction

    // -------------------------------------------------------------- driver tasks
    // Called at a negedge. Drives the request and waits (bounded) until the
    // coming edge is a transfer edge; returns at that negedge with valid high.
    task automatic issue(input bit sel_b, input logic rd, input logic [2:0] b_g,
                         input logic b_a, input logic [15:0] r, input logic [9:0] c_l);
        int n = 0;
        int acc;
        logic [3:0] col_code;
        col_code = rd ? 4'd12 : 4'd5;
        if (sel_b) begin
            valid_b = 1'b1; rd_b = rd; bg_in_b = b_g; ba_in_b = b_a; row_in_b = r; col_in_b = c_l;
            while (!ready_b && n < 100) begin @(negedge clk); n++; end
        end else begin
            valid_a = 1'b1; rd_a = rd; bg_in_a = b_g; ba_in_a = b_a; row_in_a = r; col_in_a = c_l;
            while (!ready_a && n < 100) begin @(negedge clk); n++; end
        end
        if (n >= 100) begin
            chk("ready_timeout", 64'd0, 64'd1);
        end else begin
            acc = cyc + 1;
            if (sel_b) begin
                exp_b.push_back(rec(acc, 4'd8, b_g, b_a, r, c_l));
                exp_b.push_back(rec(acc + RCD_B, col_code, b_g, b_a, r, c_l));
            end else begin
                exp_a.push_back(rec(acc, 4'd8, b_g, b_a, r, c_l));
                exp_a.push_back(rec(acc + RCD_A, col_code, b_g, b_a, r, c_l));
            end
        end
    endtask

    // -------------------------------------------------------------- stimulus + monitor
    // Hand-computed traces for cycles 1..15 after a read accept on u_a.
    logic [3:0] tr_cs_a [1:15] = '{4'd8, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                                   4'd12, 4'd12, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    logic       tr_pk_a [1:15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // Cycles 1..5 after a write accept on u_b.
    logic [3:0] tr_cs_b [1:5] = '{4'd8, 4'd8, 4'd5, 4'd5, 4'd0};
    logic       tr_pk_b [1:5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        int accepts;
        int last_acc;

        fork
            forever begin
                @(negedge clk);
                if (cs_a) begin
                    if (exp_a.size() == 0) chk("unexpected_cs_a", 64'd1, 64'd0);
                    else chk("cmd_a", 64'(rec(cyc, cur_a, bg_a, ba_a, row_a, col_a)), 64'(exp_a.pop_front()));
                end
                if (cs_b) begin
                    if (exp_b.size() == 0) chk("unexpected_cs_b", 64'd1, 64'd0);
                    else chk("cmd_b", 64'(rec(cyc, cur_b, bg_b, ba_b, row_b, col_b)), 64'(exp_b.pop_front()));
                end
            end
        join_none

        // 1. Reset held 3 cycles with req_valid high.
        valid_a = 1'b1;
        valid_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ready_a", 64'(ready_a), 64'd0);
            chk("rst_ready_b", 64'(ready_b), 64'd0);
            chk("rst_outs_a", 64'({cur_a, bg_a, ba_a, row_a, col_a, cs_a, busy_a}), 64'd0);
            chk("rst_outs_b", 64'({cur_b, bg_b, ba_b, row_b, col_b, cs_b, busy_b}), 64'd0);
        end
        rst = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        @(negedge clk);
        chk("post_rst_ready_a", 64'(ready_a), 64'd1);
        chk("post_rst_ready_b", 64'(ready_b), 64'd1);

        // 2. Read on u_a, T_RCD=8, T_REC=4.
        issue(1'b0, 1'b1, 3'd3, 1'b1, 16'hA5C3, 10'h1F4);
        for (int r = 1; r <= 15; r++) begin
            @(negedge clk);
            if (r == 1) valid_a = 1'b0;
            chk($sformatf("trace_a_cs_%0d", r), 64'(cur_a), 64'(tr_cs_a[r]));
            chk($sformatf("trace_a_pkt_%0d", r), 64'(cs_a), 64'(tr_pk_a[r]));
            chk($sformatf("trace_a_rdy_%0d", r), 64'(ready_a), (r == 15) ? 64'd1 : 64'd0);
            chk($sformatf("trace_a_busy_%0d", r), 64'(busy_a), (r == 15) ? 64'd0 : 64'd1);
        end

        // 3. Write on u_b, T_RCD=2, T_REC=0.
        issue(1'b1, 1'b0, 3'd5, 1'b0, 16'h1234, 10'h0AB);
        for (int r = 1; r <= 5; r++) begin
            @(negedge clk);
            if (r == 1) valid_b = 1'b0;
            chk($sformatf("trace_b_cs_%0d", r), 64'(cur_b), 64'(tr_cs_b[r]));
            chk($sformatf("trace_b_pkt_%0d", r), 64'(cs_b), 64'(tr_pk_b[r]));
            chk($sformatf("trace_b_rdy_%0d", r), 64'(ready_b), (r == 5) ? 64'd1 : 64'd0);
        end

        // 4. Back-to-back on u_b: valid held, fields change every cycle.
        accepts = 0;
        last_acc = 0;
        valid_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [31:0] iv;
            iv = i;
            rd_b = iv[0];
            bg_in_b = iv[2:0];
            ba_in_b = iv[1];
            row_in_b = 16'h1000 + iv[15:0];
            col_in_b = 10'h200 + iv[9:0];
            if (ready_b) begin
                exp_b.push_back(rec(cyc + 1, 4'd8, bg_in_b, ba_in_b, row_in_b, col_in_b));
                exp_b.push_back(rec(cyc + 1 + RCD_B, rd_b ? 4'd12 : 4'd5,
                                    bg_in_b, ba_in_b, row_in_b, col_in_b));
                if (accepts > 0) chk("b2b_spacing", 64'(cyc - last_acc), 64'd5);
                last_acc = cyc;
                accepts++;
            end
            @(negedge clk);
        end
        valid_b = 1'b0;
        chk("b2b_accepts", 64'(accepts), 64'd4);

        // 5. Reset during the tRCD gap of a read on u_a.
        issue(1'b0, 1'b1, 3'd6, 1'b0, 16'h0F0F, 10'h3C3);
        for (int r = 1; r <= 4; r++) begin
            @(negedge clk);
            if (r == 1) valid_a = 1'b0;
        end
        chk("mid_rst_busy_before", 64'(busy_a), 64'd1);
        rst = 1'b1;
        void'(exp_a.pop_back());   // the column command is aborted
        @(negedge clk);
        chk("mid_rst_cs", 64'(cur_a), 64'd0);
        chk("mid_rst_busy", 64'(busy_a), 64'd0);
        chk("mid_rst_pkt", 64'(cs_a), 64'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("after_rst_ready", 64'(ready_a), 64'd1);
        issue(1'b0, 1'b0, 3'd1, 1'b1, 16'hBEEF, 10'h055);
        @(negedge clk);
        valid_a = 1'b0;

        // Drain and confirm every expected command was seen.
        repeat (25) @(negedge clk);
        chk("queue_a_empty", 64'(exp_a.size()), 64'd0);
        chk("queue_b_empty", 64'(exp_b.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
